// File: rtl/gate_lab_controller.sv
// gate_lab_controller: synchronise/debounce switches and mode button, drive LEDs with the selected gate-lab function.
module gate_lab_controller #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int BLINK_CYCLES = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] switch,
  input  logic       btn,
  output logic [7:0] led
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int BW = $clog2(BLINK_CYCLES);
  typedef enum logic [2:0] {
    S_AND  = 3'b000,
    S_INV  = 3'b001,
    S_XNOR = 3'b010,
    S_MUX  = 3'b011,
    S_SCAN = 3'b100
  } state_t;
  state_t state, state_nxt;
  logic [7:0] sw_m, sw_s, sw_p, sw_db;
  logic [DW-1:0] sw_cnt, btn_cnt;
  logic btn_m, btn_s, btn_p, btn_db, btn_q, hb;
  logic [BW-1:0] hb_cnt;
  logic sw_hit, btn_hit, step, hb_wrap, f0, f1, f2, f3;
  logic [3:0] lo;
  // A change is accepted only after the synced value has held steady and differed for the full window.
  assign sw_hit = sw_s != sw_db && sw_s == sw_p && sw_cnt == DW'(DEBOUNCE_CYCLES - 1);
  assign btn_hit = btn_s != btn_db && btn_s == btn_p && btn_cnt == DW'(DEBOUNCE_CYCLES - 1);
  assign step = btn_db & ~btn_q;
  assign hb_wrap = hb_cnt == BW'(BLINK_CYCLES - 1);
  assign f0 = sw_db[0] & sw_db[1];
  assign f1 = ~(sw_db[2] & ~sw_db[3]);
  assign f2 = ~^sw_db;
  assign f3 = sw_db[4] ? f0 : f1;
  always_comb begin
    state_nxt = state;
    case (state)
      S_AND:   state_nxt = step ? S_INV : S_AND;
      S_INV:   state_nxt = step ? S_XNOR : S_INV;
      S_XNOR:  state_nxt = step ? S_MUX : S_XNOR;
      S_MUX:   state_nxt = step ? S_SCAN : S_MUX;
      S_SCAN:  state_nxt = step ? S_AND : S_SCAN;
      default: state_nxt = S_AND;
    endcase
    lo = state == S_SCAN ? {f3, f2, f1, f0} :
         {3'b000, state == S_AND ? f0 : state == S_INV ? f1 : state == S_XNOR ? f2 : f3};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_m <= '0;
      sw_s <= '0;
      sw_p <= '0;
      sw_db <= '0;
      sw_cnt <= '0;
      btn_m <= 1'b0;
      btn_s <= 1'b0;
      btn_p <= 1'b0;
      btn_db <= 1'b0;
      btn_q <= 1'b0;
      btn_cnt <= '0;
      hb_cnt <= '0;
      hb <= 1'b0;
      state <= S_AND;
      led <= 8'h00;
    end else begin
      sw_m <= switch;
      sw_s <= sw_m;
      sw_p <= sw_s;
      sw_cnt <= (sw_s == sw_db || sw_s != sw_p || sw_hit) ? '0 : sw_cnt + 1'b1;
      if (sw_hit) sw_db <= sw_s;
      btn_m <= btn;
      btn_s <= btn_m;
      btn_p <= btn_s;
      btn_cnt <= (btn_s == btn_db || btn_s != btn_p || btn_hit) ? '0 : btn_cnt + 1'b1;
      if (btn_hit) btn_db <= btn_s;
      btn_q <= btn_db;
      hb_cnt <= hb_wrap ? '0 : hb_cnt + 1'b1;
      if (hb_wrap) hb <= ~hb;
      state <= state_nxt;
      led <= {state, hb, lo};
    end
  end
endmodule
